// File: rtl/load_wb_unit.sv
// Load write-back unit: issues one aligned memory read per load, extracts and
// extends the addressed byte/halfword/word, and writes it to the register bank.
module load_wb_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  rd,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  a3,
  output logic [31:0] wd,
  output logic        we,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REG_W-1:0]    a3_q, a3_d;
  logic [1:0]          lane_q, lane_d;
  logic [2:0]          f3_q, f3_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                mem_req_q, mem_req_d;
  logic                busy_q, busy_d;

  // Alignment and opcode legality of an incoming request.
  function automatic logic is_legal(input logic [2:0] f, input logic [1:0] a);
    case (f)
      3'b000, 3'b100: is_legal = 1'b1;
      3'b001, 3'b101: is_legal = ~a[0];
      3'b010:         is_legal = (a == 2'b00);
      default:        is_legal = 1'b0;
    endcase
  endfunction

  // Select the addressed lane from the word and sign/zero extend it.
  function automatic logic [DATA_W-1:0] extract(input logic [2:0] f,
                                                input logic [1:0] lane,
                                                input logic [DATA_W-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'h000000, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'h0000, h};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a3_d       = a3_q;
    lane_d     = lane_q;
    f3_d       = f3_q;
    mem_addr_d = mem_addr_q;
    wd_d       = wd_q;
    we_d       = 1'b0;
    err_d      = 1'b0;
    mem_req_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a3_d       = rd;
          lane_d     = addr[1:0];
          f3_d       = funct3;
          mem_addr_d = {addr[31:2], 2'b00};
          if (is_legal(funct3, addr[1:0])) begin
            state_d   = S_REQ;
            cnt_d     = '0;
            mem_req_d = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          wd_d    = extract(f3_q, lane_q, mem_rdata);
          we_d    = (a3_q != '0);
          state_d = S_WB;
        end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          // Saturating count: never wraps back into a fresh timeout window.
          cnt_d     = (cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
          mem_req_d = 1'b1;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a3_q       <= '0;
      lane_q     <= '0;
      f3_q       <= '0;
      mem_addr_q <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a3_q       <= a3_d;
      lane_q     <= lane_d;
      f3_q       <= f3_d;
      mem_addr_q <= mem_addr_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign a3       = a3_q;
  assign wd       = wd_q;
  assign we       = we_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_load_wb_unit.sv
// Directed bench for load_wb_unit: extraction, illegal requests, timeout,
// busy-ignore and asynchronous reset, checked with immediate assertions.
module tb_load_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  rd;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [4:0]  a3;
  logic [31:0] wd;
  logic        we;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  load_wb_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .rd(rd), .addr(addr), .funct3(funct3),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .a3(a3), .wd(wd), .we(we), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Legal load with mem_ready on the first REQ cycle.
  task automatic run_load(input string tag, input logic [4:0] r, input logic [31:0] a,
                          input logic [2:0] f, input logic [31:0] data,
                          input logic [31:0] exp_wd, input logic exp_we);
    start = 1'b1; rd = r; addr = a; funct3 = f;
    tick();
    start = 1'b0;
    check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
    check({tag, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
    mem_ready = 1'b1; mem_rdata = data;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check({tag, ".we"}, 32'(we), 32'(exp_we));
    check({tag, ".mem_req_drop"}, 32'(mem_req), 32'd0);
    if (exp_we) begin
      check({tag, ".a3"}, 32'(a3), 32'(r));
      check({tag, ".wd"}, wd, exp_wd);
    end
    tick();
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".we_done"}, 32'(we), 32'd0);
  endtask

  // Illegal request: straight to ERR, no memory request.
  task automatic run_err(input string tag, input logic [31:0] a, input logic [2:0] f);
    start = 1'b1; rd = 5'd4; addr = a; funct3 = f;
    tick();
    start = 1'b0;
    check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd1);
    check({tag, ".we"}, 32'(we), 32'd0);
    tick();
    check({tag, ".err_clr"}, 32'(err), 32'd0);
    check({tag, ".busy_clr"}, 32'(busy), 32'd0);
    check({tag, ".mem_req2"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; rd = '0; addr = '0; funct3 = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    #12;
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.wd", wd, 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // LW with two waiting REQ cycles before ready.
    start = 1'b1; rd = 5'd5; addr = 32'h100; funct3 = 3'b010;
    tick();
    start = 1'b0;
    check("lw.mem_req1", 32'(mem_req), 32'd1);
    check("lw.mem_addr", mem_addr, 32'h100);
    check("lw.busy", 32'(busy), 32'd1);
    tick();
    check("lw.mem_req2", 32'(mem_req), 32'd1);
    tick();
    check("lw.mem_req3", 32'(mem_req), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("lw.we", 32'(we), 32'd1);
    check("lw.a3", 32'(a3), 32'd5);
    check("lw.wd", wd, 32'hDEADBEEF);
    check("lw.busy_wb", 32'(busy), 32'd1);
    tick();
    check("lw.busy_done", 32'(busy), 32'd0);
    check("lw.we_pulse", 32'(we), 32'd0);

    run_load("lb",   5'd6, 32'h103, 3'b000, 32'h80123456, 32'hFFFFFF80, 1'b1);
    run_load("lbu",  5'd7, 32'h103, 3'b100, 32'h80123456, 32'h00000080, 1'b1);
    run_load("lb1",  5'd8, 32'h101, 3'b000, 32'h80123456, 32'h00000034, 1'b1);
    run_load("lbu2", 5'd8, 32'h102, 3'b100, 32'h80123456, 32'h00000012, 1'b1);
    run_load("lh",   5'd9, 32'h102, 3'b001, 32'h7FFF8000, 32'h00007FFF, 1'b1);
    run_load("lhu",  5'd10, 32'h100, 3'b101, 32'h7FFF8000, 32'h00008000, 1'b1);
    run_load("lh0",  5'd11, 32'h100, 3'b001, 32'h7FFF8000, 32'hFFFF8000, 1'b1);
    run_load("lhu2", 5'd12, 32'h102, 3'b101, 32'h9ABC0001, 32'h00009ABC, 1'b1);
    run_load("rd0",  5'd0, 32'h104, 3'b010, 32'h12345678, 32'h12345678, 1'b0);

    run_err("lw_mis", 32'h101, 3'b010);
    run_err("f3_011", 32'h100, 3'b011);
    run_err("lh_mis", 32'h101, 3'b001);
    run_err("f3_110", 32'h100, 3'b110);
    run_err("f3_111", 32'h100, 3'b111);

    // Timeout: 15 REQ cycles, then err and a late ready is ignored.
    start = 1'b1; rd = 5'd13; addr = 32'h200; funct3 = 3'b010;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("to.mem_req%0d", i), 32'(mem_req), 32'd1);
      tick();
    end
    check("to.mem_req_drop", 32'(mem_req), 32'd0);
    check("to.err", 32'(err), 32'd1);
    check("to.we", 32'(we), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    check("to.idle", 32'(busy), 32'd0);
    check("to.err_clr", 32'(err), 32'd0);
    tick();
    mem_ready = 1'b0;
    check("to.late_we", 32'(we), 32'd0);
    check("to.late_busy", 32'(busy), 32'd0);
    check("to.late_req", 32'(mem_req), 32'd0);

    // Start while busy is dropped, not queued.
    start = 1'b1; rd = 5'd7; addr = 32'h300; funct3 = 3'b010;
    tick();
    rd = 5'd9; addr = 32'h400;
    tick();
    start = 1'b0;
    check("bz.mem_addr", mem_addr, 32'h300);
    mem_ready = 1'b1; mem_rdata = 32'h11223344;
    tick();
    mem_ready = 1'b0;
    check("bz.a3", 32'(a3), 32'd7);
    check("bz.wd", wd, 32'h11223344);
    tick();
    check("bz.busy_done", 32'(busy), 32'd0);
    tick();
    check("bz.no_queue", 32'(busy), 32'd0);

    // Asynchronous reset during REQ aborts the load.
    start = 1'b1; rd = 5'd14; addr = 32'h500; funct3 = 3'b010;
    tick();
    start = 1'b0;
    check("ar.mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar.mem_req0", 32'(mem_req), 32'd0);
    check("ar.mem_addr0", mem_addr, 32'd0);
    check("ar.busy0", 32'(busy), 32'd0);
    check("ar.a30", 32'(a3), 32'd0);
    check("ar.wd0", wd, 32'd0);
    tick();
    check("ar.we_hold", 32'(we), 32'd0);
    check("ar.err_hold", 32'(err), 32'd0);
    rst = 1'b1;
    run_load("ar.after", 5'd3, 32'h600, 3'b010, 32'h0BADF00D, 32'h0BADF00D, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
